// File: rtl/ahfp_cordic_sched.sv
// Two-requester round-robin scheduler in front of a shared, free-running CORDIC pipeline.
// Optional theta range check is enabled by defining AHFP_CORDIC_SCHED_RANGE_CHK_EN.
module ahfp_cordic_sched #(
   parameter int unsigned LATENCY   = 64,
   parameter int unsigned HIGH_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_x,
   input  logic [31:0] req0_y,
   input  logic [31:0] req0_theta,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_x,
   input  logic [31:0] req1_y,
   input  logic [31:0] req1_theta,
   input  logic        drain,
   output logic [31:0] cordic_x_start,
   output logic [31:0] cordic_y_start,
   output logic [31:0] cordic_theta,
   input  logic [31:0] cordic_x_cos,
   input  logic [31:0] cordic_y_sin,
   output logic        res_valid,
   output logic        res_id,
   output logic        res_err,
   output logic [31:0] res_x,
   output logic [31:0] res_y,
   output logic        busy,
   output logic [6:0]  outstanding
);

   localparam int unsigned CNT_W = 7;
   localparam int unsigned TAG_W = LATENCY;

   logic             prio;
   logic             grant0;
   logic             grant1;
   logic             grant;
   logic             gnt_id;
   logic [31:0]      sel_x;
   logic [31:0]      sel_y;
   logic [31:0]      sel_t;
   logic             op_err;
   logic             emerge;
   logic             emerge_err;
   logic [TAG_W-1:0] tag_v;
   logic [TAG_W-1:0] tag_id;
   logic [CNT_W-1:0] cnt_nxt;

   // prio names the requester that wins when both are valid
   assign req0_ready = !rst && !drain && (!req1_valid || (prio == 1'b0));
   assign req1_ready = !rst && !drain && (!req0_valid || (prio == 1'b1));

   assign grant0 = req0_valid & req0_ready;
   assign grant1 = req1_valid & req1_ready;
   assign grant  = grant0 | grant1;
   assign gnt_id = grant1;

   assign sel_x = gnt_id ? req1_x     : req0_x;
   assign sel_y = gnt_id ? req1_y     : req0_y;
   assign sel_t = gnt_id ? req1_theta : req0_theta;

   assign emerge = tag_v[TAG_W-1];

`ifdef AHFP_CORDIC_SCHED_RANGE_CHK_EN
   logic [TAG_W-1:0] tag_err;
   logic             res_err_q;

   // NaN/Inf exponent or magnitude beyond pi/2 is rejected
   assign op_err     = (sel_t[30:23] == 8'hFF) || (sel_t[30:0] > 31'h3FC9_0FDB);
   assign emerge_err = tag_err[TAG_W-1];
   assign res_err    = res_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_err   <= '0;
         res_err_q <= 1'b0;
      end else begin
         tag_err <= {tag_err[TAG_W-2:0], grant & op_err};
         if (emerge) begin
            res_err_q <= emerge_err;
         end else begin
            res_err_q <= 1'b0;
         end
      end
   end
`else
   assign op_err     = 1'b0;
   assign emerge_err = 1'b0;
   assign res_err    = 1'b0;
`endif

   // Decrement lands in the same cycle res_valid is presented, so the count never exceeds LATENCY
   always_comb begin
      cnt_nxt = outstanding;
      if (grant && !emerge) begin
         cnt_nxt = outstanding + CNT_W'(1);
      end else if (!grant && emerge) begin
         cnt_nxt = outstanding - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio           <= 1'(HIGH_PRIO);
         cordic_x_start <= '0;
         cordic_y_start <= '0;
         cordic_theta   <= '0;
         tag_v          <= '0;
         tag_id         <= '0;
         res_valid      <= 1'b0;
         res_id         <= 1'b0;
         res_x          <= '0;
         res_y          <= '0;
         outstanding    <= '0;
         busy           <= 1'b0;
      end else begin
         if (grant) begin
            prio           <= ~gnt_id;
            cordic_x_start <= op_err ? 32'h0 : sel_x;
            cordic_y_start <= op_err ? 32'h0 : sel_y;
            cordic_theta   <= op_err ? 32'h0 : sel_t;
         end
         tag_v     <= {tag_v[TAG_W-2:0], grant};
         tag_id    <= {tag_id[TAG_W-2:0], gnt_id & grant};
         res_valid <= emerge;
         if (emerge) begin
            res_id <= tag_id[TAG_W-1];
            res_x  <= emerge_err ? 32'h0 : cordic_x_cos;
            res_y  <= emerge_err ? 32'h0 : cordic_y_sin;
         end
         outstanding <= cnt_nxt;
         busy        <= (cnt_nxt != '0);
      end
   end

endmodule

// File: tb/tb_ahfp_cordic_sched.sv
// Directed bench for ahfp_cordic_sched with a toy CORDIC stand-in (x^theta, y+theta, LAT-1 stages).
// Range-check vectors follow AHFP_CORDIC_SCHED_RANGE_CHK_EN when defined.
module tb_ahfp_cordic_sched;

   localparam int unsigned LAT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_x, req0_y, req0_theta;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_x, req1_y, req1_theta;
   logic        drain;
   logic [31:0] cordic_x_start, cordic_y_start, cordic_theta;
   logic [31:0] cordic_x_cos, cordic_y_sin;
   logic        res_valid, res_id, res_err;
   logic [31:0] res_x, res_y;
   logic        busy;
   logic [6:0]  outstanding;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   ahfp_cordic_sched #(.LATENCY(LAT), .HIGH_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_x(req0_x), .req0_y(req0_y), .req0_theta(req0_theta),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_x(req1_x), .req1_y(req1_y), .req1_theta(req1_theta),
      .drain(drain),
      .cordic_x_start(cordic_x_start), .cordic_y_start(cordic_y_start),
      .cordic_theta(cordic_theta),
      .cordic_x_cos(cordic_x_cos), .cordic_y_sin(cordic_y_sin),
      .res_valid(res_valid), .res_id(res_id), .res_err(res_err),
      .res_x(res_x), .res_y(res_y),
      .busy(busy), .outstanding(outstanding)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in CORDIC: result visible LAT cycles after the grant cycle
   logic [31:0] mx [0:LAT-2];
   logic [31:0] my [0:LAT-2];
   always @(posedge clk) begin
      mx[0] <= cordic_x_start ^ cordic_theta;
      my[0] <= cordic_y_start + cordic_theta;
      for (int i = 1; i < LAT - 1; i++) begin
         mx[i] <= mx[i-1];
         my[i] <= my[i-1];
      end
   end
   assign cordic_x_cos = mx[LAT-2];
   assign cordic_y_sin = my[LAT-2];

   // Counter model: grants before this cycle minus results up to and including it
   bit mon_en   = 1'b0;
   bit g_prev   = 1'b0;
   bit rst_prev = 1'b1;
   int om       = 0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst_prev) om = 0;
         else om = om + (g_prev ? 1 : 0) - (res_valid ? 1 : 0);
         tests++;
         if (outstanding !== 7'(om) || busy !== (om != 0)) begin
            fails++;
            $display("FAIL outstanding_model cyc=%0d got out=%0d busy=%b want out=%0d busy=%b",
                     cyc, outstanding, busy, om, (om != 0));
         end
      end
      g_prev   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
      rst_prev = rst;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req1_valid = 1'b0; drain = 1'b0;
   endtask

   task automatic pulse_reset();
      step(); rst = 1'b1; idle_inputs();
      step(); rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; drain = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_x = 32'hAAAA_0000; req0_y = 32'h1; req0_theta = 32'h3F00_0000;
      req1_x = 32'hBBBB_0000; req1_y = 32'h2; req1_theta = 32'h3E00_0000;
      for (int i = 0; i < 3; i++) begin
         step();
         if (i == 2) mon_en = 1'b1;
         @(negedge clk);
         tests++;
         if ({req0_ready, req1_ready} !== 2'b00) begin
            fails++;
            $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready});
         end
      end
      step(); rst = 1'b0; idle_inputs();
      @(negedge clk);
      tests++;
      if ({res_valid, res_id, res_err, busy, outstanding} !== 11'h0) begin
         fails++;
         $display("FAIL reset_flags got v=%b id=%b err=%b busy=%b out=%0d want all 0",
                  res_valid, res_id, res_err, busy, outstanding);
      end
      tests++;
      if ({res_x, res_y} !== 64'h0) begin
         fails++;
         $display("FAIL reset_res got x=%h y=%h want 0", res_x, res_y);
      end
      tests++;
      if ({cordic_x_start, cordic_y_start, cordic_theta} !== 96'h0) begin
         fails++;
         $display("FAIL reset_cordic got %h %h %h want 0", cordic_x_start, cordic_y_start, cordic_theta);
      end
   endtask

   task automatic test_single();
      int n;
      bit got;
      step();
      req0_x = 32'h3F80_0000; req0_y = 32'h0; req0_theta = 32'h3F06_0A92; req0_valid = 1'b1;
      @(negedge clk);
      tests++;
      if (req0_ready !== 1'b1) begin
         fails++;
         $display("FAIL single_ready got %b want 1", req0_ready);
      end
      step(); req0_valid = 1'b0;
      @(negedge clk);
      tests++;
      if ({cordic_x_start, cordic_y_start, cordic_theta} !== {32'h3F80_0000, 32'h0, 32'h3F06_0A92}) begin
         fails++;
         $display("FAIL single_cordic got %h %h %h want 3f800000 00000000 3f060a92",
                  cordic_x_start, cordic_y_start, cordic_theta);
      end
      n = 1; got = 1'b0;
      while (!got && n < 3 * LAT) begin
         step(); @(negedge clk); n++;
         if (res_valid === 1'b1) got = 1'b1;
      end
      tests++;
      if (!got || n != LAT + 1) begin
         fails++;
         $display("FAIL single_latency got=%b n=%0d want n=%0d", got, n, LAT + 1);
      end
      tests++;
      if ({res_id, res_err, res_x, res_y} !== {1'b0, 1'b0, 32'h0086_0A92, 32'h3F06_0A92}) begin
         fails++;
         $display("FAIL single_result got id=%b err=%b x=%h y=%h want 0 0 00860a92 3f060a92",
                  res_id, res_err, res_x, res_y);
      end
      step(); @(negedge clk);
      tests++;
      if (res_valid !== 1'b0 || res_x !== 32'h0086_0A92 || res_y !== 32'h3F06_0A92) begin
         fails++;
         $display("FAIL single_hold got v=%b x=%h y=%h want 0 00860a92 3f060a92", res_valid, res_x, res_y);
      end
      // priority now points at 1, but a lone req0 must still be taken
      step(); req0_valid = 1'b1;
      @(negedge clk);
      tests++;
      if (req0_ready !== 1'b1) begin
         fails++;
         $display("FAIL single_lone_ready got %b want 1", req0_ready);
      end
      step(); req0_valid = 1'b0;
      repeat (LAT + 3) step();
   endtask

   task automatic test_round_robin();
      logic        exp_id [0:7];
      logic [31:0] exp_x  [0:7];
      logic [31:0] exp_y  [0:7];
      int g0, k;
      pulse_reset();
      k = 0; g0 = 0;
      for (int i = 0; i < 8 + LAT + 4; i++) begin
         step();
         if (i < 8) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_x = 32'h0000_1000 + 32'(i); req0_y = 32'h10; req0_theta = 32'h3F00_0000;
            req1_x = 32'h0000_2000 + 32'(i); req1_y = 32'h20; req1_theta = 32'h3F00_0000;
         end else begin
            idle_inputs();
         end
         @(negedge clk);
         if (i < 8) begin
            if (i == 0) g0 = cyc;
            exp_id[i] = 1'(i % 2);
            exp_x[i]  = ((i % 2 == 1) ? (32'h2000 + 32'(i)) : (32'h1000 + 32'(i))) ^ 32'h3F00_0000;
            exp_y[i]  = ((i % 2 == 1) ? 32'h20 : 32'h10) + 32'h3F00_0000;
            tests++;
            if ({req0_ready, req1_ready} !== {(i % 2 == 0), (i % 2 == 1)}) begin
               fails++;
               $display("FAIL rr_grant i=%0d got %b want %b", i, {req0_ready, req1_ready},
                        {(i % 2 == 0), (i % 2 == 1)});
            end
         end
         if (res_valid === 1'b1) begin
            tests++;
            if (k >= 8 || cyc != g0 + k + LAT + 1 || res_id !== exp_id[k % 8] ||
                res_x !== exp_x[k % 8] || res_y !== exp_y[k % 8]) begin
               fails++;
               $display("FAIL rr_result k=%0d got cyc=%0d id=%b x=%h y=%h want cyc=%0d id=%b x=%h y=%h",
                        k, cyc, res_id, res_x, res_y, g0 + k + LAT + 1, exp_id[k % 8], exp_x[k % 8], exp_y[k % 8]);
            end
            k++;
         end
      end
      tests++;
      if (k != 8) begin
         fails++;
         $display("FAIL rr_count got %0d want 8", k);
      end
   endtask

   task automatic test_drain();
      int nres;
      bit exp_busy;
      nres = 0;
      for (int i = 0; i < LAT + 6; i++) begin
         step();
         req0_valid = (i < 12); req1_valid = (i < 12);
         drain      = (i >= 2 && i < 12);
         req0_theta = 32'h3E00_0000; req1_theta = 32'h3E00_0000;
         @(negedge clk);
         if (i >= 2 && i < 12) begin
            tests++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
               fails++;
               $display("FAIL drain_ready i=%0d got %b want 00", i, {req0_ready, req1_ready});
            end
         end
         exp_busy = (i >= 1 && i <= LAT + 1);
         tests++;
         if (busy !== exp_busy) begin
            fails++;
            $display("FAIL drain_busy i=%0d got %b want %b", i, busy, exp_busy);
         end
         if (res_valid === 1'b1) nres++;
      end
      idle_inputs();
      tests++;
      if (nres != 2) begin
         fails++;
         $display("FAIL drain_results got %0d want 2", nres);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      seen = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         req0_valid = (i < 5) || (i == 7); req1_valid = (i == 7);
         req0_x = 32'(i); req0_y = 32'h0; req0_theta = 32'h3E00_0000;
         rst = (i == 7);
         @(negedge clk);
         if (i == 7) begin
            tests++;
            if ({req0_ready, req1_ready} !== 2'b00 || outstanding !== 7'd5) begin
               fails++;
               $display("FAIL rstmid_before got rdy=%b out=%0d want 00 5", {req0_ready, req1_ready}, outstanding);
            end
         end
         if (i == 8) begin
            tests++;
            if (outstanding !== 7'd0 || busy !== 1'b0) begin
               fails++;
               $display("FAIL rstmid_after got out=%0d busy=%b want 0 0", outstanding, busy);
            end
         end
      end
      for (int i = 0; i < 2 * LAT; i++) begin
         step(); @(negedge clk);
         if (res_valid !== 1'b0) seen++;
      end
      tests++;
      if (seen != 0) begin
         fails++;
         $display("FAIL rstmid_ghost got %0d stray results want 0", seen);
      end
   endtask

   task automatic test_range();
      logic [31:0] th [0:2];
      logic [95:0] ecord [0:2];
      logic [64:0] eres [0:2];
      int nv, n;
      bit got;
`ifdef AHFP_CORDIC_SCHED_RANGE_CHK_EN
      nv = 3;
      th[0] = 32'h4049_0FDB; ecord[0] = 96'h0;                              eres[0] = {1'b1, 64'h0};
      th[1] = 32'hBF49_0FDB; ecord[1] = {32'h3F80_0000, 32'h0, 32'hBF49_0FDB}; eres[1] = {1'b0, 32'h80C9_0FDB, 32'hBF49_0FDB};
      th[2] = 32'h7F80_0001; ecord[2] = 96'h0;                              eres[2] = {1'b1, 64'h0};
`else
      nv = 2;
      th[0] = 32'h4049_0FDB; ecord[0] = {32'h3F80_0000, 32'h0, 32'h4049_0FDB}; eres[0] = {1'b0, 32'h7FC9_0FDB, 32'h4049_0FDB};
      th[1] = 32'h7F80_0001; ecord[1] = {32'h3F80_0000, 32'h0, 32'h7F80_0001}; eres[1] = {1'b0, 32'h4000_0001, 32'h7F80_0001};
      th[2] = 32'h0;         ecord[2] = 96'h0;                              eres[2] = 65'h0;
`endif
      for (int v = 0; v < nv; v++) begin
         step();
         req0_x = 32'h3F80_0000; req0_y = 32'h0; req0_theta = th[v]; req0_valid = 1'b1;
         step(); req0_valid = 1'b0;
         @(negedge clk);
         tests++;
         if ({cordic_x_start, cordic_y_start, cordic_theta} !== ecord[v]) begin
            fails++;
            $display("FAIL range_cordic v=%0d got %h %h %h want %h", v, cordic_x_start, cordic_y_start,
                     cordic_theta, ecord[v]);
         end
         n = 1; got = 1'b0;
         while (!got && n < 3 * LAT) begin
            step(); @(negedge clk); n++;
            if (res_valid === 1'b1) got = 1'b1;
         end
         tests++;
         if (!got || n != LAT + 1 || {res_err, res_x, res_y} !== eres[v]) begin
            fails++;
            $display("FAIL range_result v=%0d got n=%0d err=%b x=%h y=%h want n=%0d %h", v, n,
                     res_err, res_x, res_y, LAT + 1, eres[v]);
         end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_round_robin();
      test_drain();
      test_reset_mid();
      test_range();
      repeat (2) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
